// File: rtl/ram2_pkg.sv
// -----------------------------------------------------------------------------
// ram2_pkg
//   Shared definitions for the ram2 controller slice: default word and address
//   widths, the default bulk-clear word, and the controller state encoding.
// -----------------------------------------------------------------------------
package ram2_pkg;

  localparam int          DEF_DATA_W    = 32;
  localparam int          DEF_ADDR_W    = 5;
  localparam logic [31:0] DEF_CLR_VALUE = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_CAP,
    ST_CLR
  } ctrl_state_e;

endpackage

// File: rtl/ram2.sv
// -----------------------------------------------------------------------------
// ram2
//   Single-port synchronous RAM with one shared bidirectional data bus.
//   A write stores the bus word at the clock edge when ena=1, wena=1.
//   A read (ena=1, wena=0) registers the addressed word at the clock edge.
//   The RAM then drives that word onto the bus for the following cycle only.
//
// Ports
//   clk   in     rising-edge clock
//   ena   in     cycle enable
//   wena  in     1 = write, 0 = read (when ena=1)
//   addr  in     word address
//   data  inout  shared data bus
// -----------------------------------------------------------------------------
module ram2
  import ram2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              ena,
  input  logic              wena,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] dout_q;
  logic              rd_oe;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values; the storage array has no reset because
  // RAM contents are undefined until written, and resetting them would force
  // the array out of RAM macros into flops.
  always_ff @(posedge clk) begin
    rd_oe <= ena && !wena;
    if (ena && wena) begin
      mem[addr] <= data;
    end
    if (ena && !wena) begin
      dout_q <= mem[addr];
    end
  end

  assign data = rd_oe ? dout_q : 'z;

endmodule

// File: rtl/ram2_ctrl.sv
// -----------------------------------------------------------------------------
// ram2_ctrl
//   Single-master controller for the ram2 single-port RAM. It converts a
//   valid/ready word-request port into RAM write and read cycles, returns
//   read data on a one-cycle response strobe, and runs a bulk clear that
//   writes CLR_VALUE to every location. The controller drives the shared bus
//   only while its registered mem_wena is high.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   req_valid/ready  request handshake (accept on valid && ready)
//   req_we           1 = write, 0 = read
//   req_addr         word address
//   req_wdata        write data
//   rsp_valid        one-cycle read-data strobe
//   rsp_rdata        read data, held until the next read response
//   clr_start        bulk-clear request, sampled in IDLE only
//   clr_busy         high while a clear is running
//   clr_done         one-cycle pulse when a clear completes
//   mem_ena/wena     RAM enable and write enable
//   mem_addr         RAM address
//   mem_data         shared RAM data bus
// -----------------------------------------------------------------------------
module ram2_ctrl
  import ram2_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] CLR_VALUE = DATA_W'(DEF_CLR_VALUE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_ena,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  ctrl_state_e       state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_ena_d, mem_wena_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              clr_done_d;

  // A clear request in IDLE wins over a pending request that cycle.
  assign req_ready = (state_q == ST_IDLE) && !clr_start;
  assign clr_busy  = (state_q == ST_CLR);

  // The output enable is exactly the registered write enable. The RAM only
  // drives in the cycle after a read, when mem_wena is always low.
  assign mem_data = mem_wena ? wdata_q : 'z;

  // All RAM pins are registered: each state computes the pin values for the
  // cycle it is entering. During a clear, mem_addr doubles as the counter.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    mem_ena_d   = 1'b0;
    mem_wena_d  = 1'b0;
    mem_addr_d  = mem_addr;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    clr_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d    = ST_CLR;
          mem_ena_d  = 1'b1;
          mem_wena_d = 1'b1;
          mem_addr_d = '0;
          wdata_d    = CLR_VALUE;
        end else if (req_valid) begin
          mem_ena_d  = 1'b1;
          mem_addr_d = req_addr;
          if (req_we) begin
            state_d    = ST_WR;
            mem_wena_d = 1'b1;
            wdata_d    = req_wdata;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      // The RAM stores the word on the edge that leaves WR.
      ST_WR: state_d = ST_IDLE;

      // The RAM registers the word on the edge that leaves RD and drives it
      // during RD_CAP.
      ST_RD: state_d = ST_RD_CAP;

      ST_RD_CAP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_data;
      end

      // Stop after the last address instead of wrapping the counter.
      ST_CLR: begin
        if (mem_addr == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end else begin
          mem_ena_d  = 1'b1;
          mem_wena_d = 1'b1;
          mem_addr_d = mem_addr + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_ena   <= 1'b0;
      mem_wena  <= 1'b0;
      mem_addr  <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      clr_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_ena   <= mem_ena_d;
      mem_wena  <= mem_wena_d;
      mem_addr  <= mem_addr_d;
      wdata_q   <= wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      clr_done  <= clr_done_d;
    end
  end

endmodule

// File: tb/tb_ram2_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram2_ctrl
//   Directed bench for ram2_ctrl connected pin-to-pin to ram2. A vector table
//   of write/read operations is applied with per-cycle handshake and timing
//   checks. Hand-written sequences cover back-to-back throughput, bulk clear,
//   clear/request collision and reset during a read.
// -----------------------------------------------------------------------------
module tb_ram2_ctrl;
  import ram2_pkg::*;

  localparam int          DATA_W  = 32;
  localparam int          ADDR_W  = 5;
  localparam logic [31:0] CLR_VAL = 32'hA5A5_A5A5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              clr_start = 1'b0;
  logic              req_ready, rsp_valid, clr_busy, clr_done;
  logic              mem_ena, mem_wena;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] rsp_rdata;
  wire  [DATA_W-1:0] mem_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc[$];
  logic [DATA_W-1:0] rsp_q[$];

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;  // write data, or expected read data
  } vec_t;

  vec_t vecs[11];

  ram2_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLR_VALUE(CLR_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  ram2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .ena(mem_ena), .wena(mem_wena), .addr(mem_addr), .data(mem_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Accept-edge and response monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && req_valid && req_ready) acc_cyc.push_back(cyc);
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid) rsp_q.push_back(rsp_rdata);
  end

  // Continuous bus rules.
  always @(negedge clk) begin
    if (rst_n) begin
      check("bus_both_drive", {63'b0, mem_wena & u_ram.rd_oe}, 64'd0);
      check("wena_without_ena", {63'b0, mem_wena & ~mem_ena}, 64'd0);
      if (dut.state_q == ST_RD_CAP) check("rdcap_bus_x", {63'b0, $isunknown(mem_data)}, 64'd0);
    end
  end

  // One request through the handshake, with cycle-by-cycle checks when chk=1.
  // Request fields are scrambled right after the accept edge.
  task automatic run_op(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input bit chk);
    int n = 0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = we ? data : ~data;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (chk) check("ready_before_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~data;
    if (chk) begin
      check("op_ena", mem_ena, 1);
      check("op_wena", mem_wena, we);
      check("op_addr", mem_addr, addr);
      check("op_ready_low", req_ready, 0);
      if (we) check("wr_bus", mem_data, data);
    end
    @(posedge clk); #1;
    if (we) begin
      if (chk) begin
        check("wr_ready_back", req_ready, 1);
        check("wr_ena_off", mem_ena, 0);
      end
    end else begin
      if (chk) begin
        check("rd_ena_off", mem_ena, 0);
        check("rd_no_early_rsp", rsp_valid, 0);
        check("rd_ready_low2", req_ready, 0);
      end
      @(posedge clk); #1;
      if (chk) begin
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_rdata, data);
        check("rd_ready_back", req_ready, 1);
      end
      @(posedge clk); #1;
      if (chk) begin
        check("rd_rsp_pulse", rsp_valid, 0);
        check("rd_rsp_hold", rsp_rdata, data);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_ena"}, mem_ena, 0);
    check({tag, "_mem_wena"}, mem_wena, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_clr_busy"}, clr_busy, 0);
    check({tag, "_clr_done"}, clr_done, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, done_k, last_busy, acc_k, n0, rsp_seen;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 5'd5,  32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'h0000_0001};
    vecs[3]  = '{1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[4]  = '{1'b0, 5'd0,  32'h0000_0001};
    vecs[5]  = '{1'b0, 5'd31, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 5'd5,  32'h0BAD_F00D};
    vecs[7]  = '{1'b0, 5'd5,  32'h0BAD_F00D};
    vecs[8]  = '{1'b1, 5'd16, 32'h8000_0000};
    vecs[9]  = '{1'b0, 5'd16, 32'h8000_0000};
    vecs[10] = '{1'b0, 5'd31, 32'hFFFF_FFFF};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table.
    foreach (vecs[i]) run_op(vecs[i].we, vecs[i].addr, vecs[i].data, 1'b1);

    // Back-to-back alternating write/read with req_valid held high.
    acc_cyc.delete();
    rsp_q.delete();
    req_we = 1'b1; req_addr = 5'd0; req_wdata = 32'h1111_1111;
    req_valid = 1'b1;
    n0 = 0;
    for (int n = 0; n < 100 && n0 < 8; n++) begin
      @(posedge clk); #1;
      if (acc_cyc.size() > n0) begin
        n0++;
        if (n0 < 8) begin
          req_we    = (n0 % 2 == 0);
          req_addr  = ADDR_W'(n0 / 2);
          req_wdata = 32'h1111_1111 * (n0 / 2 + 1);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    repeat (4) @(posedge clk);
    #1;
    check("b2b_accepts", acc_cyc.size(), 8);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("b2b_spacing_%0d", i), acc_cyc[i] - acc_cyc[i-1], ((i - 1) % 2 == 0) ? 2 : 3);
    check("b2b_rsp_count", rsp_q.size(), 4);
    for (int i = 0; i < rsp_q.size(); i++)
      check($sformatf("b2b_rdata_%0d", i), rsp_q[i], 32'h1111_1111 * (i + 1));

    // Fill, then bulk clear; a stray clr_start mid-clear must be ignored.
    for (int a = 0; a < 32; a++) run_op(1'b1, ADDR_W'(a), 32'h1000_0000 + a, 1'b0);
    clr_start = 1'b1;
    #1;
    check("clr_ready_low", req_ready, 0);
    @(posedge clk); #1;
    clr_start = 1'b0;
    busy_n = 0; done_n = 0; done_k = -1; last_busy = -1;
    for (int k = 0; k < 40; k++) begin
      if (clr_busy) begin busy_n++; last_busy = k; end
      if (clr_done) begin done_n++; done_k = k; end
      clr_start = (k == 5);
      @(posedge clk); #1;
    end
    clr_start = 1'b0;
    check("clr_busy_cycles", busy_n, 32);
    check("clr_done_pulses", done_n, 1);
    check("clr_done_cycle", done_k, 32);
    check("clr_last_busy", last_busy, 31);
    run_op(1'b0, 5'd0,  CLR_VAL, 1'b1);
    run_op(1'b0, 5'd17, CLR_VAL, 1'b1);
    run_op(1'b0, 5'd31, CLR_VAL, 1'b1);

    // Clear and request in the same IDLE cycle.
    req_we = 1'b1; req_addr = 5'd9; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    clr_start = 1'b1;
    #1;
    check("collide_ready_low", req_ready, 0);
    n0 = acc_cyc.size();
    @(posedge clk); #1;
    clr_start = 1'b0;
    acc_k = -1; done_k = -1;
    for (int k = 1; k <= 50 && acc_k < 0; k++) begin
      @(posedge clk); #1;
      if (clr_done && done_k < 0) done_k = k;
      if (acc_cyc.size() > n0) acc_k = k;
    end
    req_valid = 1'b0;
    check("collide_done_cycle", done_k, 32);
    check("collide_accept_cycle", acc_k, 33);
    @(posedge clk); #1;
    run_op(1'b0, 5'd9, 32'h1234_5678, 1'b1);

    // Reset on the cycle after a read accept.
    req_we = 1'b0; req_addr = 5'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrd");
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    check("midrd_no_rsp", rsp_seen, 0);
    run_op(1'b0, 5'd9, 32'h1234_5678, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
